// File: rtl/issue_queue_param.sv
// issue_queue_param
//
// Out-of-order issue queue. Dispatch writes an instruction into the lowest
// free slot. Operands that are not yet available wait for their tag on the
// common data bus (CDB). Each cycle the oldest entry whose operands are all
// present and whose target functional unit is ready is presented for issue.
//
// Optional feature, selected by the ISSUE_WAKEUP_BYPASS_EN macro:
//   undefined - a CDB wakeup makes an entry eligible in the following cycle.
//   defined   - a CDB wakeup makes an entry eligible in the broadcast cycle,
//               and the operand is taken directly from cdb_data_i.
//
// Ports
//   clk_i, reset_i       clock, synchronous active-high reset
//   flush_i              discard every resident entry
//   enq_*                dispatch handshake, operands, target FU, payload
//   cdb_valid/tag/data_i NUM_CDB_P result broadcasts, packed per port
//   issue_valid_o        one-hot per-FU issue strobe (all zero when idle)
//   issue_ready_i        per-FU ready
//   issue_src1/src2_o    operands of the presented entry (0 when idle)
//   issue_payload_o      payload of the presented entry (0 when idle)
//   count_o              number of occupied entries
module issue_queue_param #(
    parameter int ENTRIES_P   = 8,
    parameter int NUM_CDB_P   = 4,
    parameter int NUM_FU_P    = 4,
    parameter int TAG_W_P     = 6,
    parameter int DATA_W_P    = 16,
    parameter int PAYLOAD_W_P = 32,
    localparam int IDX_W      = $clog2(ENTRIES_P),
    localparam int CNT_W      = IDX_W + 1,
    localparam int FU_W       = (NUM_FU_P > 1) ? $clog2(NUM_FU_P) : 1
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           flush_i,
    input  logic                           enq_valid_i,
    output logic                           enq_ready_o,
    input  logic [TAG_W_P-1:0]             enq_src1_tag_i,
    input  logic [TAG_W_P-1:0]             enq_src2_tag_i,
    input  logic                           enq_src1_v_i,
    input  logic                           enq_src2_v_i,
    input  logic [DATA_W_P-1:0]            enq_src1_data_i,
    input  logic [DATA_W_P-1:0]            enq_src2_data_i,
    input  logic [FU_W-1:0]                enq_fu_i,
    input  logic [PAYLOAD_W_P-1:0]         enq_payload_i,
    input  logic [NUM_CDB_P-1:0]           cdb_valid_i,
    input  logic [NUM_CDB_P*TAG_W_P-1:0]   cdb_tag_i,
    input  logic [NUM_CDB_P*DATA_W_P-1:0]  cdb_data_i,
    output logic [NUM_FU_P-1:0]            issue_valid_o,
    input  logic [NUM_FU_P-1:0]            issue_ready_i,
    output logic [DATA_W_P-1:0]            issue_src1_o,
    output logic [DATA_W_P-1:0]            issue_src2_o,
    output logic [PAYLOAD_W_P-1:0]         issue_payload_o,
    output logic [CNT_W-1:0]               count_o
);

    // Entry table
    logic [ENTRIES_P-1:0]   valid_q, valid_d;
    logic [ENTRIES_P-1:0]   s1v_q, s1v_d;
    logic [ENTRIES_P-1:0]   s2v_q, s2v_d;
    logic [TAG_W_P-1:0]     s1t_q [ENTRIES_P];
    logic [TAG_W_P-1:0]     s1t_d [ENTRIES_P];
    logic [TAG_W_P-1:0]     s2t_q [ENTRIES_P];
    logic [TAG_W_P-1:0]     s2t_d [ENTRIES_P];
    logic [DATA_W_P-1:0]    s1d_q [ENTRIES_P];
    logic [DATA_W_P-1:0]    s1d_d [ENTRIES_P];
    logic [DATA_W_P-1:0]    s2d_q [ENTRIES_P];
    logic [DATA_W_P-1:0]    s2d_d [ENTRIES_P];
    logic [FU_W-1:0]        fu_q  [ENTRIES_P];
    logic [FU_W-1:0]        fu_d  [ENTRIES_P];
    logic [PAYLOAD_W_P-1:0] pl_q  [ENTRIES_P];
    logic [PAYLOAD_W_P-1:0] pl_d  [ENTRIES_P];
    // older_q[i][j] set means entry i was accepted before entry j. Only
    // rows/columns of valid entries are meaningful.
    logic [ENTRIES_P-1:0]   older_q [ENTRIES_P];
    logic [ENTRIES_P-1:0]   older_d [ENTRIES_P];
    logic [CNT_W-1:0]       count_q, count_d;

    // CDB match results
    logic [ENTRIES_P-1:0]   s1_hit, s2_hit;
    logic [DATA_W_P-1:0]    s1_hd [ENTRIES_P];
    logic [DATA_W_P-1:0]    s2_hd [ENTRIES_P];
    logic                   enq_s1_hit, enq_s2_hit;
    logic [DATA_W_P-1:0]    enq_s1_hd, enq_s2_hd;

    // Selection
    logic [ENTRIES_P-1:0]   s1_rdy, s2_rdy, fu_rdy, elig, blocked;
    logic                   sel_found;
    logic [IDX_W-1:0]       sel_idx;
    logic [IDX_W-1:0]       enq_idx;
    logic                   enq_fire;

    // Returns {hit, data}; scanning from the top down lets the lowest
    // matching port overwrite any higher one.
    function automatic logic [DATA_W_P:0] cdb_lookup(
        input logic [TAG_W_P-1:0]            tag,
        input logic [NUM_CDB_P-1:0]          vld,
        input logic [NUM_CDB_P*TAG_W_P-1:0]  tags,
        input logic [NUM_CDB_P*DATA_W_P-1:0] datas
    );
        logic [DATA_W_P:0] r;
        r = '0;
        for (int k = NUM_CDB_P - 1; k >= 0; k--) begin
            if (vld[k] && (tags[k*TAG_W_P +: TAG_W_P] == tag)) begin
                r = {1'b1, datas[k*DATA_W_P +: DATA_W_P]};
            end
        end
        return r;
    endfunction

    always_comb begin
        for (int i = 0; i < ENTRIES_P; i++) begin
            {s1_hit[i], s1_hd[i]} = cdb_lookup(s1t_q[i], cdb_valid_i, cdb_tag_i, cdb_data_i);
            {s2_hit[i], s2_hd[i]} = cdb_lookup(s2t_q[i], cdb_valid_i, cdb_tag_i, cdb_data_i);
        end
        {enq_s1_hit, enq_s1_hd} = cdb_lookup(enq_src1_tag_i, cdb_valid_i, cdb_tag_i, cdb_data_i);
        {enq_s2_hit, enq_s2_hd} = cdb_lookup(enq_src2_tag_i, cdb_valid_i, cdb_tag_i, cdb_data_i);
    end

`ifdef ISSUE_WAKEUP_BYPASS_EN
    assign s1_rdy = s1v_q | s1_hit;
    assign s2_rdy = s2v_q | s2_hit;
`else
    assign s1_rdy = s1v_q;
    assign s2_rdy = s2v_q;
`endif

    always_comb begin
        fu_rdy = '0;
        for (int i = 0; i < ENTRIES_P; i++) begin
            for (int f = 0; f < NUM_FU_P; f++) begin
                if (fu_q[i] == FU_W'(f)) begin
                    fu_rdy[i] = issue_ready_i[f];
                end
            end
        end
    end

    assign elig = valid_q & s1_rdy & s2_rdy & fu_rdy;

    // An eligible entry is blocked if any other eligible entry is older;
    // exactly one eligible entry survives.
    always_comb begin
        blocked   = '0;
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = 0; i < ENTRIES_P; i++) begin
            for (int j = 0; j < ENTRIES_P; j++) begin
                if (j != i && elig[j] && older_q[j][i]) begin
                    blocked[i] = 1'b1;
                end
            end
        end
        for (int i = 0; i < ENTRIES_P; i++) begin
            if (elig[i] && !blocked[i]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    // The presented entry's operand is either resident or, in bypass mode,
    // still in flight on the CDB this cycle.
    always_comb begin
        issue_valid_o   = '0;
        issue_src1_o    = '0;
        issue_src2_o    = '0;
        issue_payload_o = '0;
        if (sel_found) begin
            for (int f = 0; f < NUM_FU_P; f++) begin
                issue_valid_o[f] = (fu_q[sel_idx] == FU_W'(f));
            end
            issue_src1_o    = s1v_q[sel_idx] ? s1d_q[sel_idx] : s1_hd[sel_idx];
            issue_src2_o    = s2v_q[sel_idx] ? s2d_q[sel_idx] : s2_hd[sel_idx];
            issue_payload_o = pl_q[sel_idx];
        end
    end

    // Lowest free slot from registered occupancy; a slot issuing this cycle
    // still reads as occupied, so it is not reused until the next cycle.
    always_comb begin
        enq_idx = '0;
        for (int i = ENTRIES_P - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                enq_idx = IDX_W'(i);
            end
        end
    end

    assign enq_ready_o = (count_q != CNT_W'(ENTRIES_P));
    assign enq_fire    = enq_valid_i & enq_ready_o & ~flush_i;
    assign count_o     = count_q;

    always_comb begin
        valid_d = valid_q;
        s1v_d   = s1v_q;
        s2v_d   = s2v_q;
        s1t_d   = s1t_q;
        s2t_d   = s2t_q;
        s1d_d   = s1d_q;
        s2d_d   = s2d_q;
        fu_d    = fu_q;
        pl_d    = pl_q;
        older_d = older_q;
        count_d = count_q;
        if (flush_i) begin
            valid_d = '0;
            count_d = '0;
        end else begin
            for (int i = 0; i < ENTRIES_P; i++) begin
                if (valid_q[i] && !s1v_q[i] && s1_hit[i]) begin
                    s1v_d[i] = 1'b1;
                    s1d_d[i] = s1_hd[i];
                end
                if (valid_q[i] && !s2v_q[i] && s2_hit[i]) begin
                    s2v_d[i] = 1'b1;
                    s2d_d[i] = s2_hd[i];
                end
            end
            if (sel_found) begin
                valid_d[sel_idx] = 1'b0;
            end
            if (enq_fire) begin
                valid_d[enq_idx] = 1'b1;
                s1t_d[enq_idx]   = enq_src1_tag_i;
                s2t_d[enq_idx]   = enq_src2_tag_i;
                s1v_d[enq_idx]   = enq_src1_v_i | enq_s1_hit;
                s2v_d[enq_idx]   = enq_src2_v_i | enq_s2_hit;
                s1d_d[enq_idx]   = enq_src1_v_i ? enq_src1_data_i : enq_s1_hd;
                s2d_d[enq_idx]   = enq_src2_v_i ? enq_src2_data_i : enq_s2_hd;
                fu_d[enq_idx]    = enq_fu_i;
                pl_d[enq_idx]    = enq_payload_i;
                // New entry is younger than everything already resident.
                older_d[enq_idx] = '0;
                for (int j = 0; j < ENTRIES_P; j++) begin
                    if (IDX_W'(j) != enq_idx) begin
                        older_d[j][enq_idx] = 1'b1;
                    end
                end
            end
            if (enq_fire && !sel_found) begin
                count_d = count_q + CNT_W'(1);
            end else if (!enq_fire && sel_found) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_q <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    // Entry contents are qualified by valid_q and need no reset.
    always_ff @(posedge clk_i) begin
        s1v_q   <= s1v_d;
        s2v_q   <= s2v_d;
        s1t_q   <= s1t_d;
        s2t_q   <= s2t_d;
        s1d_q   <= s1d_d;
        s2d_q   <= s2d_d;
        fu_q    <= fu_d;
        pl_q    <= pl_d;
        older_q <= older_d;
    end

endmodule

// File: doc/issue_queue_param.md
ISSUE_QUEUE_PARAM -- requirements
Module: issue_queue_param

Interface
REQ-001 SHALL have parameter ENTRIES_P, default 8, queue depth, power of two, 2..32.
REQ-002 SHALL have parameter NUM_CDB_P, default 4, number of CDB broadcast ports.
REQ-003 SHALL have parameter NUM_FU_P, default 4, number of functional-unit issue ports.
REQ-004 SHALL have parameters TAG_W_P, default 6 (physical tag width), DATA_W_P, default 16 (operand width), and PAYLOAD_W_P, default 32 (opaque opcode/dest/ROB bundle width).
REQ-005 SHALL have port clk_i, input, 1, sole clock; reset_i, input, 1, synchronous active-high reset.
REQ-006 SHALL have port flush_i, input, 1, discards all entries.
REQ-007 SHALL have enq_valid_i (in, 1) and enq_ready_o (out, 1), the dispatch handshake.
REQ-008 SHALL have enq_src1_tag_i / enq_src2_tag_i (in, TAG_W_P), enq_src1_v_i / enq_src2_v_i (in, 1), and enq_src1_data_i / enq_src2_data_i (in, DATA_W_P), the operands at dispatch.
REQ-009 SHALL have enq_fu_i (in, clog2(NUM_FU_P)), the target FU, and enq_payload_i (in, PAYLOAD_W_P).
REQ-010 SHALL have cdb_valid_i (in, NUM_CDB_P), cdb_tag_i (in, NUM_CDB_P x TAG_W_P) and cdb_data_i (in, NUM_CDB_P x DATA_W_P).
REQ-011 SHALL have issue_valid_o (out, NUM_FU_P, at most one bit set) and issue_ready_i (in, NUM_FU_P).
REQ-012 SHALL have issue_src1_o / issue_src2_o (out, DATA_W_P) and issue_payload_o (out, PAYLOAD_W_P).
REQ-013 SHALL have count_o (out, clog2(ENTRIES_P)+1), the number of occupied entries.

Function
REQ-014 SHALL drive enq_ready_o = (count_o != ENTRIES_P) from registered state only; a same-cycle issue SHALL NOT raise it.
REQ-015 Enqueue SHALL occur when enq_valid_i & enq_ready_o & ~flush_i; the entry SHALL take the lowest-index free slot.
REQ-016 Each entry SHALL record an age; the oldest entry is the earliest accepted still resident.
REQ-017 Each cycle, each valid entry with a not-yet-valid operand whose tag equals cdb_tag_i[k] with cdb_valid_i[k] SHALL capture cdb_data_i[k] and set that operand valid; on multiple matches the lowest k SHALL win.
REQ-018 CDB capture SHALL also apply to the entry being enqueued in the same cycle, so no wakeup is lost.
REQ-019 An entry SHALL be eligible when valid, both operands are valid, and issue_ready_i[fu] is high.
REQ-020 Among eligible entries, the single oldest SHALL be presented: issue_valid_o[fu]=1, with its operands and payload driven combinationally from table state.
REQ-021 The presented entry SHALL be freed at the clock edge, and count_o SHALL decrement; at most one issue per cycle.
REQ-022 When no entry is eligible, issue_valid_o SHALL be 0 and the data outputs SHALL be 0.
REQ-023 On simultaneous enqueue and issue, count_o SHALL be unchanged, and the freed slot SHALL NOT be reused in that cycle.
REQ-024 With both operands valid at dispatch, the entry SHALL be eligible no earlier than the cycle after enqueue.
REQ-025 flush_i SHALL invalidate all entries and set count_o=0 at the next edge; enqueue SHALL be ignored that cycle, while issue outputs that cycle remain valid-but-discarded.
REQ-026 Relative age order of resident entries SHALL be preserved across any mix of enqueue and issue.

Reset
REQ-027 reset_i high at an edge SHALL clear all entries; count_o=0, enq_ready_o=1, and issue_valid_o=0 from the following cycle.
REQ-028 Reset mid-operation SHALL discard all entries with no partial issue; reset SHALL dominate flush_i and enq_valid_i.

Configuration
REQ-029 With ISSUE_WAKEUP_BYPASS_EN defined, an entry whose last missing operand matches a CDB broadcast in cycle N SHALL be eligible in cycle N, with the operand taken directly from cdb_data_i.
REQ-030 Without ISSUE_WAKEUP_BYPASS_EN, that entry SHALL become eligible in cycle N+1; all other behaviour is identical.

Verification
REQ-031 Reset, then enqueue 8 entries with ready operands, fu=0, issue_ready_i=0 -> enq_ready_o=0 and count_o=8 after the 8th; raise ready -> issue in enqueue order, one per cycle.
REQ-032 Entry A (src1 tag 5, not valid) is older than entry B (ready); CDB port 2 broadcasts tag 5, data 0x1234 -> B issues first, then A with issue_src1_o=0x1234. A issues in the broadcast cycle with ISSUE_WAKEUP_BYPASS_EN, the next cycle without.
REQ-033 Enqueue src2 tag 9 in the same cycle CDB port 0 broadcasts tag 9, data 0xBEEF -> entry later issues with issue_src2_o=0xBEEF.
REQ-034 Oldest entry targets fu=1 with issue_ready_i[1]=0; a younger entry targets fu=2 with issue_ready_i[2]=1 -> issue_valid_o=4'b0100.
REQ-035 Full queue, flush_i pulsed together with enq_valid_i -> count_o=0 and enq_ready_o=1 the next cycle; the flushed-cycle enqueue is never issued.
REQ-036 Tag 3 broadcast on CDB ports 1 and 3 with different data -> the waiting entry captures the port-1 data.
